// File: rtl/timer_cntr_ctrl_pkg.sv
// Shared definitions for the interval timer controller.
// Holds the FSM state encoding, the mode constants and a busy decode helper.
package timer_cntr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_AUTO    = 1'b1;

  function automatic logic state_is_busy(input state_e s);
    return (s == ST_LOAD) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/timer_cntr_ctrl_cntr.sv
// n-bit loadable up counter with asynchronous clear and ripple-carry-out.
// Load has priority over increment; rco flags the all-ones value.
module cntr_up_clr_nb #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         up,
  input  logic         ld,
  input  logic [n-1:0] D,
  output logic [n-1:0] count,
  output logic         rco
);

  logic [n-1:0] count_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
    end else if (ld) begin
      count_q <= D;
    end else if (up) begin
      count_q <= count_q + n'(1);
    end
  end

  assign count = count_q;
  assign rco   = &count_q;

endmodule

// File: rtl/timer_cntr_ctrl.sv
// Interval timer sequencer: drives the loadable up counter with a prescaled
// enable, detects expiry and handles one-shot / auto-reload operation.
module timer_cntr_ctrl #(
  parameter int N     = 8,
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_rld,
  input  logic [N-1:0]     reload_val,
  input  logic [PSC_W-1:0] prescale,
  output logic [N-1:0]     count,
  output logic             busy,
  output logic             intr,
  output logic             done
);

  import timer_cntr_ctrl_pkg::*;

  state_e           state_q, state_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [PSC_W-1:0] psc_cfg_q, psc_cfg_d;
  logic             mode_q, mode_d;
  logic             intr_q, intr_d;
  logic             done_q, done_d;
  logic             cnt_up, cnt_ld, cnt_rco;
  logic             tick;

  cntr_up_clr_nb #(
    .n(N)
  ) u_datapath (
    .clk  (clk),
    .clr  (clr),
    .up   (cnt_up),
    .ld   (cnt_ld),
    .D    (reload_val),
    .count(count),
    .rco  (cnt_rco)
  );

  assign tick = (psc_q == psc_cfg_q);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      psc_q     <= '0;
      psc_cfg_q <= '0;
      mode_q    <= MODE_ONESHOT;
      intr_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      psc_q     <= psc_d;
      psc_cfg_q <= psc_cfg_d;
      mode_q    <= mode_d;
      intr_q    <= intr_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    psc_d     = psc_q;
    psc_cfg_d = psc_cfg_q;
    mode_d    = mode_q;
    intr_d    = 1'b0;
    done_d    = done_q;
    cnt_up    = 1'b0;
    cnt_ld    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        psc_d = '0;
        // stop takes precedence even when nothing is running
        if (start && !stop) begin
          mode_d    = auto_rld;
          psc_cfg_d = prescale;
          done_d    = 1'b0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        psc_d = '0;
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          mode_d    = auto_rld;
          psc_cfg_d = prescale;
          done_d    = 1'b0;
        end else begin
          cnt_ld  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          psc_d   = '0;
          state_d = ST_IDLE;
        end else if (start) begin
          // restart discards any tick landing on this edge
          psc_d     = '0;
          mode_d    = auto_rld;
          psc_cfg_d = prescale;
          done_d    = 1'b0;
          state_d   = ST_LOAD;
        end else if (tick) begin
          psc_d = '0;
          if (cnt_rco) begin
            intr_d = 1'b1;
            if (mode_q == MODE_AUTO) begin
              cnt_ld = 1'b1;
            end else begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            cnt_up = 1'b1;
          end
        end else begin
          psc_d = psc_q + PSC_W'(1);
        end
      end
    endcase
  end

  assign busy = state_is_busy(state_q);
  assign intr = intr_q;
  assign done = done_q;

endmodule

// File: tb/tb_timer_cntr_ctrl.sv
// Directed bench for the interval timer controller; expected values are
// hand-derived from the edge-by-edge behaviour of the timer.
module tb_timer_cntr_ctrl;

  localparam int N     = 8;
  localparam int PSC_W = 8;

  logic             clk = 1'b0;
  logic             clr;
  logic             start;
  logic             stop;
  logic             auto_rld;
  logic [N-1:0]     reload_val;
  logic [PSC_W-1:0] prescale;
  logic [N-1:0]     count;
  logic             busy;
  logic             intr;
  logic             done;

  int n_chk  = 0;
  int n_pass = 0;

  timer_cntr_ctrl #(
    .N    (N),
    .PSC_W(PSC_W)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .stop      (stop),
    .auto_rld  (auto_rld),
    .reload_val(reload_val),
    .prescale  (prescale),
    .count     (count),
    .busy      (busy),
    .intr      (intr),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a start pulse sampled on the next edge (E0); returns just after E0.
  task automatic cmd_start(input logic a, input logic [N-1:0] rv, input logic [PSC_W-1:0] ps);
    auto_rld   = a;
    reload_val = rv;
    prescale   = ps;
    start      = 1'b1;
    step();
    start      = 1'b0;
    $display("txn start auto=%0d reload=0x%0h prescale=%0d", a, rv, ps);
  endtask

  task automatic do_oneshot();
    cmd_start(1'b0, 8'hFC, 8'd0);
    chk("os_e0_done", done, 0);
    chk("os_e0_busy", busy, 1);
    step(); chk("os_e1_count", count, 32'hFC);
    step(); chk("os_e2_count", count, 32'hFD);
    step(); chk("os_e3_count", count, 32'hFE);
    step(); chk("os_e4_count", count, 32'hFF);
    chk("os_e4_intr", intr, 0);
    step(); chk("os_e5_intr", intr, 1);
    chk("os_e5_done", done, 1);
    chk("os_e5_busy", busy, 0);
    chk("os_e5_count", count, 32'hFF);
    step(); chk("os_e6_intr", intr, 0);
    chk("os_e6_done", done, 1);
    chk("os_e6_count", count, 32'hFF);
  endtask

  initial begin
    int pulses;
    logic seen;
    logic [N-1:0] exp_cnt;

    clr = 1'b1; start = 1'b0; stop = 1'b0;
    auto_rld = 1'b0; reload_val = '0; prescale = '0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_intr", intr, 0);
    chk("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;

    // one-shot
    do_oneshot();

    // auto-reload, prescale 1: tick every 2 clocks, expiry every 8
    cmd_start(1'b1, 8'hFC, 8'd1);
    chk("au_done_clr", done, 0);
    step(); chk("au_e1_count", count, 32'hFC);
    pulses = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      exp_cnt = 8'hFC + N'((k / 2) % 4);
      chk("au_count", count, 32'(exp_cnt));
      chk("au_intr", intr, (k % 8 == 0) ? 1 : 0);
      if (intr) pulses++;
    end
    chk("au_pulses", pulses, 4);
    $display("txn auto run pulses=%0d", pulses);

    // stop mid-run at count FE
    cmd_start(1'b1, 8'hFC, 8'd1);
    repeat (5) step();
    chk("sp_pre_count", count, 32'hFE);
    stop = 1'b1; step(); stop = 1'b0;
    $display("txn stop");
    chk("sp_busy", busy, 0);
    chk("sp_count", count, 32'hFE);
    seen = 1'b0;
    repeat (20) begin
      step();
      chk("sp_hold", count, 32'hFE);
      seen = seen | intr;
    end
    chk("sp_no_intr", seen, 0);
    cmd_start(1'b1, 8'hFC, 8'd1);
    chk("sp_e0_count", count, 32'hFE);
    step(); chk("sp_rld_count", count, 32'hFC);
    chk("sp_rld_busy", busy, 1);

    // start+stop together while running: stop wins, no reload
    reload_val = 8'h10; start = 1'b1; stop = 1'b1;
    step(); start = 1'b0; stop = 1'b0;
    $display("txn start+stop");
    chk("ss_busy", busy, 0);
    chk("ss_count", count, 32'hFC);
    step(); chk("ss_count2", count, 32'hFC);
    chk("ss_busy2", busy, 0);

    // stop on the expiry tick
    cmd_start(1'b0, 8'hFC, 8'd0);
    repeat (4) step();
    chk("se_pre_count", count, 32'hFF);
    stop = 1'b1; step(); stop = 1'b0;
    $display("txn stop on expiry");
    chk("se_intr", intr, 0);
    chk("se_busy", busy, 0);
    chk("se_count", count, 32'hFF);
    chk("se_done", done, 0);
    step(); chk("se_intr2", intr, 0);
    chk("se_count2", count, 32'hFF);

    // asynchronous reset between edges mid-run
    cmd_start(1'b0, 8'hFC, 8'd0);
    step(); step();
    chk("ar_pre_count", count, 32'hFD);
    #2 clr = 1'b1;
    #1;
    $display("txn async clr");
    chk("ar_count", count, 0);
    chk("ar_busy", busy, 0);
    chk("ar_intr", intr, 0);
    chk("ar_done", done, 0);
    #2 clr = 1'b0;
    step();
    do_oneshot();

    // reload all-ones, auto: expiry on every clock
    cmd_start(1'b1, 8'hFF, 8'd0);
    step(); chk("ff_e1_count", count, 32'hFF);
    chk("ff_e1_intr", intr, 0);
    repeat (5) begin
      step();
      chk("ff_intr", intr, 1);
      chk("ff_count", count, 32'hFF);
    end
    stop = 1'b1; step(); stop = 1'b0;
    chk("ff_stop_busy", busy, 0);
    chk("ff_stop_intr", intr, 0);

    // max prescale, reload FE: expiry 2x256 clocks after load
    cmd_start(1'b0, 8'hFE, 8'hFF);
    step(); chk("mp_e1_count", count, 32'hFE);
    repeat (255) step();
    chk("mp_255_count", count, 32'hFE);
    step(); chk("mp_256_count", count, 32'hFF);
    repeat (255) step();
    chk("mp_511_intr", intr, 0);
    chk("mp_511_busy", busy, 1);
    step(); chk("mp_512_intr", intr, 1);
    chk("mp_512_done", done, 1);
    chk("mp_512_busy", busy, 0);
    $display("txn max prescale expiry");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/timer_cntr_ctrl.md
Name: timer_cntr_ctrl

Overview:
- Sequencing controller for the team's n-bit loadable up counter (clr/up/ld/D/count/rco interface); turns it into a programmable interval timer.
- Handles start/stop commands, prescaled count enable, terminal-count detection, one-shot vs auto-reload modes, and a single-cycle interrupt pulse.
- Sits between the MCU's memory-mapped timer registers and the counter datapath.

Parameters:
N, 8, counter width in bits
PSC_W, 8, prescaler width in bits

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous, active-high reset
start  input  1  pulse: (re)load counter and begin timing
stop  input  1  pulse: halt timing, hold count
auto_rld  input  1  1 = auto-reload on expiry, 0 = one-shot; sampled with start
reload_val  input  N  start value for the counter; sampled on every load
prescale  input  PSC_W  tick every prescale+1 clocks; sampled with start
count  output  N  current counter value
busy  output  1  high in LOAD or RUN
intr  output  1  one-cycle expiry pulse
done  output  1  sticky; set on one-shot expiry, cleared by start or clr

Behaviour:
- Reset (async, clr=1): state IDLE; count=0, busy=0, intr=0, done=0; prescaler=0; captured mode/prescale=0. Reset mid-operation aborts immediately with no intr.
- States: IDLE, LOAD, RUN, DONE. Encoding is 2 bits.
- IDLE/DONE: counter holds (up=0, ld=0). When start=1, capture auto_rld and prescale, clear done, and go to LOAD.
- LOAD (1 cycle): assert ld with D=reload_val and reset the prescaler to 0. Go to RUN, so count==reload_val after this edge.
- RUN: prescaler increments each clock. A tick occurs when prescaler==captured prescale; the prescaler then wraps to 0.
  - Tick with count != all-ones: assert up, count+1.
  - Tick with count == all-ones (rco): expiry. intr is registered high for exactly the next cycle.
    - Auto mode: ld with reload_val on the same edge; stay in RUN.
    - One-shot mode: go to DONE; count holds all-ones; set done.
- Period per expiry is (2^N - reload_val) ticks x (prescale+1) clocks. reload_val = all-ones gives a 1-tick period. Counter arithmetic wraps mod 2^N only through reload, never via increment.
- stop in LOAD or RUN: go to IDLE on the next edge and hold count. The prescaler is cleared. No intr, done unchanged.
- start in RUN or LOAD: restart, going to LOAD with new captured config. Any pending tick is discarded.
- start and stop in the same cycle: stop wins.
- stop on an expiry tick: stop wins, so no intr and no reload.
- start in DONE: treated as in IDLE.
- busy is a combinational decode of state (LOAD or RUN). intr and done are registered.
- The controller never drives the counter's clr from start/stop. The counter's clr is tied to the block's clr.

Decomposition:
- Shared package/header: state encodings (ST_IDLE, ST_LOAD, ST_RUN, ST_DONE) and mode constants (MODE_ONESHOT=0, MODE_AUTO=1).
- One sub-module, instantiated as the datapath: the existing n-bit loadable up counter cntr_up_clr_nb with n=N.
- FSM, prescaler and config capture live in timer_cntr_ctrl.

Test Plan:
- One-shot: N=8, reload_val=0xFC, prescale=0, start at edge E0.
  - count: FC@E1, FD@E2, FE@E3, FF@E4.
  - intr=1 for the single cycle after E5.
  - done=1 and busy=0 after E5; count stays 0xFF.
- Auto-reload: reload_val=0xFC, prescale=1.
  - count changes every 2 clocks.
  - intr pulses every 8 clocks; count returns to 0xFC on each pulse edge.
  - Run 4 periods and confirm exactly 4 pulses.
- Stop mid-run: in auto mode, stop when count=0xFE.
  - busy=0 next cycle; count holds 0xFE for 20 clocks; no intr.
  - Then start: count reloads to 0xFC after 2 edges.
- Conflicts:
  - start and stop asserted together while RUN gives IDLE and no reload.
  - stop coincident with the expiry tick gives no intr and count=0xFF held.
- Async reset mid-RUN: assert clr between clock edges.
  - count=0, busy=0, intr=0, done=0 immediately, without waiting for a clock edge.
  - Re-start behaves as the one-shot case.
- Edge config:
  - reload_val=0xFF, prescale=0, auto: intr every clock after the first LOAD.
  - prescale=0xFF, reload_val=0xFE: expiry after 2x256 clocks.
